// File: rtl/id_ex_operand_stage_if.sv
// id_ex_operand_stage_if: ID inputs, MEM/WB forwarding sources and ALU-side outputs of the ID/EX stage
interface id_ex_operand_stage_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR      = 5
);
  logic                     stall;
  logic                     flush;
  logic                     id_valid;
  logic [REG_ADDR-1:0]      id_rs1;
  logic [REG_ADDR-1:0]      id_rs2;
  logic [REG_ADDR-1:0]      id_rd;
  logic [DATA_WIDTH-1:0]    id_rs1_data;
  logic [DATA_WIDTH-1:0]    id_rs2_data;
  logic [DATA_WIDTH-1:0]    id_imm;
  logic                     id_alu_src;
  logic [OPCODE_LENGTH-1:0] id_alu_op;
  logic                     id_reg_write;
  logic                     id_mem_read;
  logic                     id_mem_write;
  logic                     mem_reg_write;
  logic [REG_ADDR-1:0]      mem_rd;
  logic [DATA_WIDTH-1:0]    mem_result;
  logic                     wb_reg_write;
  logic [REG_ADDR-1:0]      wb_rd;
  logic [DATA_WIDTH-1:0]    wb_result;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic [DATA_WIDTH-1:0]    ex_store_data;
  logic [REG_ADDR-1:0]      ex_rd;
  logic                     ex_valid;
  logic                     ex_reg_write;
  logic                     ex_mem_read;
  logic                     ex_mem_write;
  logic                     load_use_hazard;
  modport master (
    output stall, flush, id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           id_alu_src, id_alu_op, id_reg_write, id_mem_read, id_mem_write,
           mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
    input  SrcA, SrcB, Operation, ex_store_data, ex_rd, ex_valid, ex_reg_write,
           ex_mem_read, ex_mem_write, load_use_hazard
  );
  modport slave (
    input  stall, flush, id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           id_alu_src, id_alu_op, id_reg_write, id_mem_read, id_mem_write,
           mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
    output SrcA, SrcB, Operation, ex_store_data, ex_rd, ex_valid, ex_reg_write,
           ex_mem_read, ex_mem_write, load_use_hazard
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with MEM/WB operand forwarding and load-use detection
module id_ex_operand_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR      = 5
) (
  input logic            clk,
  input logic            reset,
  id_ex_operand_stage_if.slave bus
);
  typedef struct packed {
    logic                     valid;
    logic                     reg_write;
    logic                     mem_read;
    logic                     mem_write;
    logic                     alu_src;
    logic [OPCODE_LENGTH-1:0] alu_op;
    logic [REG_ADDR-1:0]      rs1;
    logic [REG_ADDR-1:0]      rs2;
    logic [REG_ADDR-1:0]      rd;
    logic [DATA_WIDTH-1:0]    rs1_data;
    logic [DATA_WIDTH-1:0]    rs2_data;
    logic [DATA_WIDTH-1:0]    imm;
  } stage_t;
  stage_t stage_q, stage_d, load;
  logic [DATA_WIDTH-1:0] fwd_a, fwd_b;
  always_comb begin
    load = '{valid:     bus.id_valid,
             reg_write: bus.id_valid & bus.id_reg_write,
             mem_read:  bus.id_valid & bus.id_mem_read,
             mem_write: bus.id_valid & bus.id_mem_write,
             alu_src:   bus.id_alu_src,
             alu_op:    bus.id_alu_op,
             rs1:       bus.id_rs1,
             rs2:       bus.id_rs2,
             rd:        bus.id_rd,
             rs1_data:  bus.id_rs1_data,
             rs2_data:  bus.id_rs2_data,
             imm:       bus.id_imm};
    stage_d = bus.flush ? '0 : bus.stall ? stage_q : load;
  end
  always_ff @(posedge clk) begin
    if (reset) stage_q <= '0;
    else stage_q <= stage_d;
  end
  // The != 0 guards keep x0 from ever picking up a forwarded value
  always_comb begin
    fwd_a = (bus.mem_reg_write && bus.mem_rd != '0 && bus.mem_rd == stage_q.rs1) ? bus.mem_result :
            (bus.wb_reg_write && bus.wb_rd != '0 && bus.wb_rd == stage_q.rs1) ? bus.wb_result :
            stage_q.rs1_data;
    fwd_b = (bus.mem_reg_write && bus.mem_rd != '0 && bus.mem_rd == stage_q.rs2) ? bus.mem_result :
            (bus.wb_reg_write && bus.wb_rd != '0 && bus.wb_rd == stage_q.rs2) ? bus.wb_result :
            stage_q.rs2_data;
  end
  assign bus.SrcA          = fwd_a;
  assign bus.SrcB          = stage_q.alu_src ? stage_q.imm : fwd_b;
  assign bus.ex_store_data = fwd_b;
  assign bus.Operation     = stage_q.alu_op;
  assign bus.ex_rd         = stage_q.rd;
  assign bus.ex_valid      = stage_q.valid;
  assign bus.ex_reg_write  = stage_q.reg_write;
  assign bus.ex_mem_read   = stage_q.mem_read;
  assign bus.ex_mem_write  = stage_q.mem_write;
  // Conservative: rs2 match counts even if the ID instruction does not read rs2
  assign bus.load_use_hazard = bus.id_valid & stage_q.valid & stage_q.mem_read & (stage_q.rd != '0) &
                               ((stage_q.rd == bus.id_rs1) | (stage_q.rd == bus.id_rs2));
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: table-driven vectors checked through an expected-result queue
module tb_id_ex_operand_stage;
  typedef struct packed {
    logic        v;
    logic [4:0]  r1, r2, rd;
    logic [31:0] d1, d2, imm;
    logic        src;
    logic [3:0]  op;
    logic        rw, mr, mw;
  } id_t;
  typedef struct packed {
    logic        mrw;
    logic [4:0]  mrd;
    logic [31:0] mres;
    logic        wrw;
    logic [4:0]  wrd;
    logic [31:0] wres;
  } fw_t;
  typedef struct packed {
    logic [31:0] a, b, st;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        v, rw, mr, mw, luh;
  } exp_t;
  typedef struct packed {
    logic stall, flush;
    id_t  id;
    fw_t  f;
    exp_t e;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  vec_t tv[18];
  id_ex_operand_stage_if bus();
  id_ex_operand_stage dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic id_t mk_id(logic v, logic [4:0] r1, logic [4:0] r2, logic [4:0] rd,
                                logic [31:0] d1, logic [31:0] d2, logic [31:0] imm, logic src,
                                logic [3:0] op, logic rw, logic mr, logic mw);
    return '{v, r1, r2, rd, d1, d2, imm, src, op, rw, mr, mw};
  endfunction
  function automatic fw_t mk_fw(logic mrw, logic [4:0] mrd, logic [31:0] mres,
                                logic wrw, logic [4:0] wrd, logic [31:0] wres);
    return '{mrw, mrd, mres, wrw, wrd, wres};
  endfunction
  function automatic exp_t mk_e(logic [31:0] a, logic [31:0] b, logic [31:0] st, logic [3:0] op,
                                logic [4:0] rd, logic v, logic rw, logic mr, logic mw, logic luh);
    return '{a, b, st, op, rd, v, rw, mr, mw, luh};
  endfunction
  task automatic chk(input string tag, input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s %s: got %0h expected %0h", tag, n, a, e);
    end
  endtask
  task automatic cmp_all(input string tag, input exp_t e);
    chk(tag, "SrcA", bus.SrcA, e.a);
    chk(tag, "SrcB", bus.SrcB, e.b);
    chk(tag, "ex_store_data", bus.ex_store_data, e.st);
    chk(tag, "Operation", 32'(bus.Operation), 32'(e.op));
    chk(tag, "ex_rd", 32'(bus.ex_rd), 32'(e.rd));
    chk(tag, "ex_valid", 32'(bus.ex_valid), 32'(e.v));
    chk(tag, "ex_reg_write", 32'(bus.ex_reg_write), 32'(e.rw));
    chk(tag, "ex_mem_read", 32'(bus.ex_mem_read), 32'(e.mr));
    chk(tag, "ex_mem_write", 32'(bus.ex_mem_write), 32'(e.mw));
    chk(tag, "load_use_hazard", 32'(bus.load_use_hazard), 32'(e.luh));
  endtask
  task automatic drive(input logic stall, input logic flush, input id_t id, input fw_t f);
    bus.stall = stall;
    bus.flush = flush;
    bus.id_valid = id.v;
    bus.id_rs1 = id.r1;
    bus.id_rs2 = id.r2;
    bus.id_rd = id.rd;
    bus.id_rs1_data = id.d1;
    bus.id_rs2_data = id.d2;
    bus.id_imm = id.imm;
    bus.id_alu_src = id.src;
    bus.id_alu_op = id.op;
    bus.id_reg_write = id.rw;
    bus.id_mem_read = id.mr;
    bus.id_mem_write = id.mw;
    bus.mem_reg_write = f.mrw;
    bus.mem_rd = f.mrd;
    bus.mem_result = f.mres;
    bus.wb_reg_write = f.wrw;
    bus.wb_rd = f.wrd;
    bus.wb_result = f.wres;
  endtask
  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    drive(v.stall, v.flush, v.id, v.f);
    sb.push_back(v.e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue expected one entry", tag);
    end else cmp_all(tag, sb.pop_front());
  endtask
  initial begin
    fw_t nf;
    id_t zi;
    id_t junk;
    nf = mk_fw(0, 0, 0, 0, 0, 0);
    zi = mk_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    junk = mk_id(1, 12, 12, 3, 32'hdead, 32'hbeef, 1, 0, 4'hf, 1, 1, 1);
    tv[0]  = '{1'b0, 1'b0, mk_id(1, 1, 2, 5, 5, 9, 7, 1, 4'b0010, 1, 0, 0), nf,
               mk_e(5, 7, 9, 4'b0010, 5, 1, 1, 0, 0, 0)};
    tv[1]  = '{1'b0, 1'b0, mk_id(0, 3, 4, 7, 32'h11, 32'h22, 0, 0, 4'b0001, 1, 1, 1), nf,
               mk_e(32'h11, 32'h22, 32'h22, 4'b0001, 7, 0, 0, 0, 0, 0)};
    tv[2]  = '{1'b0, 1'b0, mk_id(1, 3, 0, 8, 32'h55, 32'h66, 0, 0, 0, 0, 0, 0),
               mk_fw(1, 3, 32'hAA, 1, 3, 32'hBB),
               mk_e(32'hAA, 32'h66, 32'h66, 0, 8, 1, 0, 0, 0, 0)};
    tv[3]  = '{1'b1, 1'b0, junk, mk_fw(0, 3, 32'hAA, 1, 3, 32'hBB),
               mk_e(32'hBB, 32'h66, 32'h66, 0, 8, 1, 0, 0, 0, 0)};
    tv[4]  = '{1'b0, 1'b0, mk_id(1, 0, 0, 2, 32'h77, 32'h88, 0, 0, 4'b0111, 0, 0, 0),
               mk_fw(1, 0, 32'hAA, 1, 0, 32'hBB),
               mk_e(32'h77, 32'h88, 32'h88, 4'b0111, 2, 1, 0, 0, 0, 0)};
    tv[5]  = '{1'b0, 1'b0, mk_id(1, 10, 11, 12, 32'h100, 32'h200, 32'h300, 1, 4'b0110, 1, 0, 0), nf,
               mk_e(32'h100, 32'h300, 32'h200, 4'b0110, 12, 1, 1, 0, 0, 0)};
    for (int i = 6; i < 9; i++) tv[i] = '{1'b1, 1'b0, junk, nf, tv[5].e};
    tv[9]  = '{1'b1, 1'b1, junk, nf, mk_e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tv[10] = '{1'b0, 1'b0, mk_id(1, 1, 2, 4, 32'h1000, 0, 8, 1, 4'b0010, 1, 1, 0), nf,
               mk_e(32'h1000, 8, 0, 4'b0010, 4, 1, 1, 1, 0, 0)};
    tv[11] = '{1'b1, 1'b0, mk_id(1, 7, 4, 9, 0, 0, 0, 0, 0, 1, 0, 0), nf,
               mk_e(32'h1000, 8, 0, 4'b0010, 4, 1, 1, 1, 0, 1)};
    tv[12] = '{1'b1, 1'b0, mk_id(0, 7, 4, 9, 0, 0, 0, 0, 0, 1, 0, 0), nf,
               mk_e(32'h1000, 8, 0, 4'b0010, 4, 1, 1, 1, 0, 0)};
    tv[13] = '{1'b0, 1'b0, mk_id(1, 1, 2, 0, 32'h1000, 0, 8, 1, 4'b0010, 1, 1, 0), nf,
               mk_e(32'h1000, 8, 0, 4'b0010, 0, 1, 1, 1, 0, 0)};
    tv[14] = '{1'b1, 1'b0, mk_id(1, 0, 0, 9, 0, 0, 0, 0, 0, 1, 0, 0), nf,
               mk_e(32'h1000, 8, 0, 4'b0010, 0, 1, 1, 1, 0, 0)};
    tv[15] = '{1'b0, 1'b0, mk_id(1, 0, 6, 0, 3, 5, 32'h40, 1, 4'b0010, 0, 0, 1),
               mk_fw(1, 6, 32'h1234, 1, 6, 32'hBB),
               mk_e(3, 32'h40, 32'h1234, 4'b0010, 0, 1, 0, 0, 1, 0)};
    tv[16] = '{1'b1, 1'b0, junk, mk_fw(1, 5, 32'h999, 1, 6, 32'hBB),
               mk_e(3, 32'h40, 32'hBB, 4'b0010, 0, 1, 0, 0, 1, 0)};
    tv[17] = '{1'b0, 1'b1, tv[5].id, nf, mk_e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    drive(1'b0, 1'b0, zi, nf);
    repeat (2) @(posedge clk);
    #1;
    cmp_all("reset", mk_e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    cmp_all("idle", mk_e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 18; i++) apply($sformatf("vec%0d", i), tv[i]);
    apply("preload", tv[5]);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b0, junk, nf);
    @(posedge clk);
    #1;
    cmp_all("reset_over_stall", mk_e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
